// File: rtl/matrix_col_scanner.sv
// Five-column LED matrix scanner with an Avalon-MM register window.
// Software writes row patterns into shadow registers; the scanner copies
// them into active registers only at scan start and at frame boundaries,
// so a frame is never displayed with a mix of old and new patterns.
module matrix_col_scanner #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_en,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [4:0]  col_n,
    output logic [6:0]  row,
    output logic        frame_done
);

    localparam int unsigned NCOL  = 5;
    localparam int unsigned ROW_W = 7;
    localparam int unsigned CNT_W = 20;
    localparam int unsigned IDX_W = 3;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [IDX_W-1:0] COL_LAST   = IDX_W'(NCOL - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   col_idx_q, col_idx_d;
    logic [ROW_W-1:0]   shadow_q [NCOL];
    logic [ROW_W-1:0]   active_q [NCOL];
    logic               load_active;
    logic               frame_end;
    logic               wr_en;
    logic               scanning;
    logic [NCOL-1:0]    col_n_d;
    logic [ROW_W-1:0]   row_d;

    assign wr_en    = chipselect && !write_n;
    assign scanning = (state_q != ST_IDLE);

    // Next-state logic: dwell counting, column advance, frame wrap and scan abort
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_idx_d   = col_idx_q;
        load_active = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_en) begin
                    state_d     = ST_BLANK;
                    col_idx_d   = '0;
                    cnt_d       = '0;
                    load_active = 1'b1;
                end
            end
            ST_BLANK: begin
                if (!scan_en) begin
                    state_d   = ST_IDLE;
                    col_idx_d = '0;
                    cnt_d     = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SCAN: begin
                if (!scan_en) begin
                    state_d   = ST_IDLE;
                    col_idx_d = '0;
                    cnt_d     = '0;
                end else if (cnt_q == DIV_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (col_idx_q == COL_LAST) begin
                        col_idx_d   = '0;
                        frame_end   = 1'b1;
                        load_active = 1'b1;
                    end else begin
                        col_idx_d = col_idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                col_idx_d = '0;
                cnt_d     = '0;
            end
        endcase
    end

    // Output drive derived from the upcoming state so the pins line up with it
    always_comb begin
        col_n_d = '1;
        row_d   = '0;
        if (state_d == ST_SCAN) begin
            col_n_d = ~(NCOL'(1) << col_idx_d);
            row_d   = active_q[col_idx_d];
        end
    end

    // Read mux: shadow registers, then status word, zero elsewhere
    always_comb begin
        readdata = '0;
        for (int i = 0; i < NCOL; i++) begin
            if (address == IDX_W'(i)) begin
                readdata = {25'b0, shadow_q[i]};
            end
        end
        if (address == 3'd5) begin
            readdata = {28'b0, col_idx_q, scanning};
        end
    end

    // State, counter, column index and registered pin outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            col_idx_q  <= '0;
            col_n      <= '1;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            col_idx_q  <= col_idx_d;
            col_n      <= col_n_d;
            row        <= row_d;
            frame_done <= frame_end;
        end
    end

    // Shadow registers take bus writes; active copies sample the pre-write shadows
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCOL; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCOL; i++) begin
                if (load_active) begin
                    active_q[i] <= shadow_q[i];
                end
                if (wr_en && (address == IDX_W'(i))) begin
                    shadow_q[i] <= writedata[ROW_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_col_scanner.sv
// Bench for matrix_col_scanner: directed scenarios plus random traffic,
// all compared against a frame-position model of the display timing.
module tb_matrix_col_scanner;

    localparam int DIV_P   = 4;
    localparam int BLANK_P = 2;
    localparam int SLOT    = DIV_P + BLANK_P;
    localparam int FRAME   = 5 * SLOT;

    logic        clk;
    logic        reset;
    logic        scan_en;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [4:0]  col_n;
    logic [6:0]  row;
    logic        frame_done;

    matrix_col_scanner #(.DIV(DIV_P), .BLANK(BLANK_P)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_en    (scan_en),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .col_n      (col_n),
        .row        (row),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: scanning flag, cycles since scan start, register contents
    bit         m_run;
    int         m_t;
    bit         m_fd;
    logic [6:0] m_shadow [5];
    logic [6:0] m_active [5];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance the model by one clock edge using the inputs presented to the DUT
    task automatic model_step();
        m_fd = 1'b0;
        if (reset) begin
            m_run = 1'b0;
            m_t   = 0;
            for (int i = 0; i < 5; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            return;
        end
        if (m_run && !scan_en) begin
            m_run = 1'b0;
            m_t   = 0;
        end else if (!m_run && scan_en) begin
            m_run = 1'b1;
            m_t   = 0;
            for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
        end else if (m_run) begin
            m_t++;
            if (m_t % FRAME == 0) begin
                m_fd = 1'b1;
                for (int i = 0; i < 5; i++) m_active[i] = m_shadow[i];
            end
        end
        if (chipselect && !write_n && address < 3'd5) m_shadow[address] = writedata[6:0];
    endtask

    task automatic check_outputs();
        logic [4:0]  e_col;
        logic [6:0]  e_row;
        logic [31:0] e_rd;
        int p, c, w;
        e_col = 5'h1f;
        e_row = '0;
        c     = 0;
        if (m_run) begin
            p = m_t % FRAME;
            c = p / SLOT;
            w = p % SLOT;
            if (w >= BLANK_P) begin
                e_col = 5'h1f & ~(5'(1) << c);
                e_row = m_active[c];
            end
        end
        if (address < 3'd5)       e_rd = {25'b0, m_shadow[address]};
        else if (address == 3'd5) e_rd = m_run ? {28'b0, 3'(c), 1'b1} : 32'h0;
        else                      e_rd = 32'h0;
        check_eq("col_n", 32'(col_n), 32'(e_col));
        check_eq("row", 32'(row), 32'(e_row));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
        check_eq("readdata", readdata, e_rd);
    endtask

    // One clock: present inputs, clock, update model, compare just after the edge
    task automatic tick(input bit rst, input bit en, input bit we, input logic [2:0] addr, input logic [6:0] wd);
        reset      = rst;
        scan_en    = en;
        chipselect = we | 1'($urandom_range(0, 1));
        write_n    = !we;
        address    = addr;
        writedata  = {25'($urandom()), wd};
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic advance_to(input int pos);
        for (int i = 0; i < 2 * FRAME && !(m_run && (m_t % FRAME) == pos); i++)
            tick(0, 1, 0, 3'd5, 7'h0);
        check_eq("advance_to", 32'(m_t % FRAME), 32'(pos));
    endtask

    int fd_cnt;
    int fd_t;

    initial begin
        clk = 0; reset = 1; scan_en = 0; address = 0;
        chipselect = 0; write_n = 1; writedata = 0;
        m_run = 0; m_t = 0; m_fd = 0;
        for (int i = 0; i < 5; i++) begin m_shadow[i] = '0; m_active[i] = '0; end

        // Reset, single register write/read, idle status
        tick(1, 0, 0, 3'd0, 7'h0);
        tick(1, 1, 1, 3'd0, 7'h3c);
        check_eq("rst_col_n", 32'(col_n), 32'h1f);
        check_eq("rst_row", 32'(row), 32'h0);
        tick(0, 0, 1, 3'd0, 7'h7f);
        tick(0, 0, 0, 3'd0, 7'h0);
        check_eq("rd_addr0", readdata, 32'h7f);
        tick(0, 0, 0, 3'd5, 7'h0);
        check_eq("rd_status_idle", readdata, 32'h0);
        tick(0, 0, 1, 3'd6, 7'h11);
        tick(0, 0, 0, 3'd6, 7'h0);
        check_eq("rd_addr6", readdata, 32'h0);

        // One full frame with a walking-one pattern
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 3'(i), 7'(1 << i));
        tick(0, 1, 0, 3'd5, 7'h0);
        check_eq("start_blank", 32'(col_n), 32'h1f);
        fd_cnt = 0; fd_t = -1;
        for (int k = 1; k <= FRAME; k++) begin
            tick(0, 1, 0, 3'd5, 7'h0);
            if (frame_done) begin fd_cnt++; fd_t = k; end
            if (k == 2)  begin check_eq("col0_n", 32'(col_n), 32'h1e); check_eq("col0_row", 32'(row), 32'h01); end
            if (k == 8)  begin check_eq("col1_n", 32'(col_n), 32'h1d); check_eq("col1_row", 32'(row), 32'h02); end
            if (k == 29) begin check_eq("col4_n", 32'(col_n), 32'h0f); check_eq("col4_row", 32'(row), 32'h10); end
        end
        check_eq("fd_count", 32'(fd_cnt), 32'd1);
        check_eq("fd_period", 32'(fd_t), 32'(FRAME));

        // Mid-frame shadow write only appears from the next frame
        advance_to(14);
        tick(0, 1, 1, 3'd2, 7'h55);
        check_eq("col2_old", 32'(row), 32'h04);
        advance_to(0);
        advance_to(14);
        check_eq("col2_new", 32'(row), 32'h55);

        // Write landing exactly on the frame-end load edge
        advance_to(FRAME - 1);
        tick(0, 1, 1, 3'd1, 7'h33);
        check_eq("load_fd", 32'(frame_done), 32'h1);
        advance_to(8);
        check_eq("col1_prewrite", 32'(row), 32'h02);
        advance_to(0);
        advance_to(8);
        check_eq("col1_postwrite", 32'(row), 32'h33);

        // Drop and re-raise scan enable during column 3
        advance_to(20);
        tick(0, 0, 0, 3'd5, 7'h0);
        check_eq("abort_col_n", 32'(col_n), 32'h1f);
        check_eq("abort_status", readdata, 32'h0);
        tick(0, 0, 0, 3'd5, 7'h0);
        tick(0, 1, 0, 3'd5, 7'h0);
        tick(0, 1, 0, 3'd5, 7'h0);
        check_eq("restart_blank", 32'(col_n), 32'h1f);
        tick(0, 1, 0, 3'd5, 7'h0);
        check_eq("restart_col0", 32'(col_n), 32'h1e);

        // Reset in the middle of column 1
        advance_to(9);
        tick(1, 1, 1, 3'd3, 7'h7f);
        check_eq("midrst_col_n", 32'(col_n), 32'h1f);
        check_eq("midrst_row", 32'(row), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 3'(i), 7'h0);
            check_eq("midrst_shadow", readdata, 32'h0);
        end

        // Random traffic: writes, reads, enable toggles, occasional reset
        for (int n = 0; n < 2500; n++) begin
            tick($urandom_range(0, 299) == 0,
                 m_run ? ($urandom_range(0, 59) != 0) : ($urandom_range(0, 7) != 0),
                 $urandom_range(0, 3) == 0,
                 3'($urandom_range(0, 7)),
                 7'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
